// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO frame reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_rd_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_frame_reader_skid_buf2.sv
// Two-entry {data,last} buffer that absorbs FIFO read latency ahead of the output stream.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: the caller never pushes when full; push and pop in one cycle keep occupancy.
module skid_buf2
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic [1:0]        count
);

  localparam logic [1:0] FULL = 2'(SKID_DEPTH);

  logic [DATA_W-1:0] data1;
  logic              last1;

  // Entry 0 is the head; entry 1 shifts forward when the head leaves.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      head_data <= '0;
      head_last <= 1'b0;
      data1     <= '0;
      last1     <= 1'b0;
      count     <= 2'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        if (count == FULL) begin
          head_data <= data1;
          head_last <= last1;
          if (push) begin
            data1 <= push_data;
            last1 <= push_last;
          end
        end else if (push) begin
          head_data <= push_data;
          head_last <= push_last;
        end
      end else if (push) begin
        if (count == 2'd0) begin
          head_data <= push_data;
          head_last <= push_last;
        end else begin
          data1 <= push_data;
          last1 <= push_last;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_frame_reader.sv
// Pops bytes from a sync FIFO and emits them as fixed-length frames with a last marker.
// Latency: first byte valid 2 cycles after entering FETCH, then 1 byte/cycle.
// Backpressure: m_ready low stops reads once buffer plus in-flight bytes reach 2.
module fifo_frame_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_count
);

  state_t          state, state_nxt;
  logic [LEN_W:0]  len_q, len_in, req_cnt, req_inc, out_cnt, out_inc;
  logic            inflight, inflight_last;
  logic [1:0]      occ;
  logic [2:0]      fill;
  logic            head_last, xfer, credit, pop_last, frame_done, start;

  // A zero length field stands for the full 2^LEN_W bytes.
  assign len_in     = (frame_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, frame_len};
  assign req_inc    = req_cnt + 1'b1;
  assign out_inc    = out_cnt + 1'b1;
  assign pop_last   = (req_inc == len_q);
  assign xfer       = m_valid && m_ready;
  assign frame_done = xfer && (out_inc == len_q);

  // Credit counts the byte leaving this cycle as freed space, so a
  // read can issue every cycle while the consumer keeps up.
  assign fill   = {1'b0, occ} + {2'b00, inflight};
  assign credit = fill < (3'd2 + {2'b00, xfer});

  assign m_valid = (occ != 2'd0);
  assign m_last  = m_valid && head_last;
  assign busy    = (state != IDLE);

  // Next-state and read strobe; frames always run to completion.
  always_comb begin
    state_nxt = state;
    fifo_rd   = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          start     = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        fifo_rd = !fifo_empty && credit;
        if (fifo_rd && pop_last) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (frame_done) begin
          if (enable) begin
            start     = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Length latch, per-frame counters, read pipeline and frame counter.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      len_q         <= '0;
      req_cnt       <= '0;
      out_cnt       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      frame_count   <= '0;
    end else begin
      inflight      <= fifo_rd;
      inflight_last <= fifo_rd && pop_last;
      if (start) begin
        len_q   <= len_in;
        req_cnt <= '0;
        out_cnt <= '0;
      end else begin
        if (fifo_rd) req_cnt <= req_inc;
        if (xfer)    out_cnt <= out_inc;
      end
      if (state == FLUSH && frame_done) frame_count <= frame_count + 1'b1;
    end
  end

  skid_buf2 #(.DATA_W(DATA_W)) u_skid (
    .clock     (clock),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_data),
    .push_last (inflight_last),
    .pop       (xfer),
    .head_data (m_data),
    .head_last (head_last),
    .count     (occ)
  );

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Bench for fifo_frame_reader: FIFO source model, stream scoreboard, table rows and corner sequences.
// Latency: n/a.
// Backpressure: m_ready driven fixed or randomly per scenario.
module tb_fifo_frame_reader;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 8;
  localparam int CNT_W  = 16;

  logic              clock = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [LEN_W-1:0]  frame_len;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready;
  logic              busy;
  logic [CNT_W-1:0]  frame_count;

  always #5 clock = ~clock;

  fifo_frame_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .enable      (enable),
    .frame_len   (frame_len),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_rd     (fifo_rd),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .busy        (busy),
    .frame_count (frame_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] fq[$];     // bytes sitting in the FIFO
  logic [7:0] exp_q[$];  // every byte pushed, in order: the expected output stream
  int pops, xfers, mdl_len, first_cyc, last_cyc, rdy_pct;
  bit pop_now, rand_rdy;

  typedef struct {
    int len;
    int nbytes;
    int rdy;
    int frames;
    int first;
    int span;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stream scoreboard: bytes leave in push order, every mdl_len-th is last,
  // and the number of completed frames before a byte is its index / length.
  task automatic monitor();
    logic [7:0] eb;
    check("held_le_2", ((pops - xfers) <= 2) ? 32'd1 : 32'd0, 32'd1);
    pop_now = fifo_rd && !fifo_empty;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_xfer: got byte %0h expected none", m_data);
      end else begin
        eb = exp_q.pop_front();
        check("m_data", m_data, eb);
        check("m_last", m_last, (((xfers + 1) % mdl_len) == 0) ? 32'd1 : 32'd0);
        check("frame_count_run", frame_count, xfers / mdl_len);
      end
      if (xfers == 0) first_cyc = cyc;
      last_cyc = cyc;
      xfers++;
    end
    if (pop_now) pops++;
  endtask

  // One clock: monitor at negedge, FIFO read data updates after the edge,
  // then stimulus settles at posedge+2.
  task automatic tick();
    @(negedge clock);
    monitor();
    @(posedge clock);
    cyc++;
    #1;
    if (pop_now) fifo_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
    #1;
    if (rand_rdy) m_ready = (int'($urandom_range(99)) < rdy_pct);
  endtask

  task automatic push_byte(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic set_len(input int len);
    frame_len = LEN_W'(len);
    mdl_len   = (len == 0) ? 256 : len;
  endtask

  task automatic clear_model();
    fq.delete();
    exp_q.delete();
    pops = 0;
    xfers = 0;
    pop_now = 1'b0;
    first_cyc = -1;
    last_cyc = -1;
    fifo_empty = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fifo_rd"}, fifo_rd, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_count"}, frame_count, 0);
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rand_rdy = 1'b0;
    m_ready = 1'b1;
    rst_n = 1'b0;
    clear_model();
    fifo_data = '0;
    set_len(4);
    tick();
    check_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (xfers < n && k < budget) begin
      tick();
      k++;
    end
    check(name, xfers, n);
  endtask

  initial begin
    int en_cyc, e0, rd_seen;

    tbl[0] = '{4,   8, 100, 2, 2, 9};
    tbl[1] = '{3,   9,  50, 3, 0, 0};
    tbl[2] = '{1,   5,  60, 5, 0, 0};
    tbl[3] = '{0, 256, 100, 1, 2, 255};
    tbl[4] = '{7,  20,  40, 2, 0, 0};
    tbl[5] = '{5,  10,  75, 2, 0, 0};

    // Table rows: enable held high, fixed length, all bytes preloaded.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      set_len(tbl[i].len);
      for (int k = 0; k < tbl[i].nbytes; k++) push_byte(8'($urandom));
      rdy_pct  = tbl[i].rdy;
      rand_rdy = (tbl[i].rdy < 100);
      m_ready  = 1'b1;
      enable   = 1'b1;
      en_cyc   = cyc;
      run_until(tbl[i].nbytes, 3000, "row_xfers");
      rand_rdy = 1'b0;
      repeat (3) tick();
      check("row_frames", frame_count, tbl[i].frames);
      check("row_busy", busy, 1);
      if (tbl[i].rdy == 100) begin
        check("row_first_lat", first_cyc - en_cyc - 1, tbl[i].first);
        check("row_span", last_cyc - first_cyc, tbl[i].span);
      end
    end

    // Consumer stalled: only two reads may be outstanding.
    do_reset();
    set_len(3);
    push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
    m_ready = 1'b0;
    enable = 1'b1;
    repeat (10) tick();
    check("stall_pops", pops, 2);
    check("stall_valid", m_valid, 1);
    check("stall_head", m_data, 8'hAA);
    m_ready = 1'b1;
    run_until(3, 50, "stall_xfers");
    repeat (3) tick();
    check("stall_frames", frame_count, 1);

    // Empty FIFO at start, bytes trickle in.
    do_reset();
    set_len(2);
    enable = 1'b1;
    e0 = cyc;
    for (int r = 1; r <= 16; r++) begin
      tick();
      if (cyc - e0 == 4)  check("empty_no_pop", pops, 0);
      if (cyc - e0 == 5)  push_byte(8'h55);
      if (cyc - e0 == 8)  check("gap_valid_a", m_valid, 0);
      if (cyc - e0 == 9)  push_byte(8'h66);
      if (cyc - e0 == 10) check("gap_valid_b", m_valid, 0);
    end
    run_until(2, 20, "trickle_xfers");
    check("trickle_frames", frame_count, 1);
    check("trickle_pops", pops, 2);

    // enable dropped mid-frame: frame completes, then idle.
    do_reset();
    set_len(4);
    for (int k = 0; k < 6; k++) push_byte(8'(8'h10 + k));
    enable = 1'b1;
    run_until(1, 20, "drop_first");
    enable = 1'b0;
    run_until(4, 50, "drop_xfers");
    repeat (4) tick();
    check("drop_frames", frame_count, 1);
    check("drop_busy", busy, 0);
    rd_seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (fifo_rd) rd_seen++;
      tick();
    end
    check("drop_no_rd", rd_seen, 0);
    check("drop_left", fq.size(), 2);
    check("drop_pops", pops, 4);

    // Asynchronous reset mid-frame, then a clean frame.
    do_reset();
    set_len(8);
    for (int k = 0; k < 8; k++) push_byte(8'($urandom));
    m_ready = 1'b0;
    enable = 1'b1;
    repeat (5) tick();
    check("pre_arst_busy", busy, 1);
    check("pre_arst_valid", m_valid, 1);
    #1 rst_n = 1'b0;
    #1 check_zero("arst");
    enable = 1'b0;
    clear_model();
    tick();
    tick();
    check("arst_hold_frames", frame_count, 0);
    rst_n = 1'b1;
    tick();
    check("post_arst_busy", busy, 0);
    set_len(2);
    push_byte(8'h3C); push_byte(8'hC3);
    m_ready = 1'b1;
    enable = 1'b1;
    run_until(2, 30, "post_arst_xfers");
    repeat (3) tick();
    check("post_arst_frames", frame_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
